// File: rtl/gpca_sched.sv
`default_nettype none
// ============================================================================
// Module      : gpca_sched
// Description : Two-port request scheduler/sequencer for the 9-row GPCA
//               divide/square-root array. Arbitrates two valid/ready
//               requesters, registers the winning operands onto the array
//               inputs, waits SETTLE_CYCLES, captures F/S and returns them
//               with the requester ID over a valid/ready response channel.
//               Optional macro GPCA_SCHED_RR_EN selects round-robin
//               arbitration; when undefined, requester 0 has fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
module gpca_sched #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [1:0]  req_x,
    input  logic [17:0] req_p,
    input  logic [35:0] req_a,
    input  logic [37:0] req_b,
    input  logic [37:0] req_c,
    output logic        arr_x,
    output logic [8:0]  arr_p,
    output logic [17:0] arr_a,
    output logic [18:0] arr_b,
    output logic [18:0] arr_c,
    input  logic [8:0]  arr_f,
    input  logic [18:0] arr_s,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic        rsp_x,
    output logic [8:0]  rsp_f,
    output logic [18:0] rsp_s,
    output logic        busy
);

    localparam int                 c_CNT_W    = 4;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_id;
    logic               r_arr_x;
    logic [8:0]         r_arr_p;
    logic [17:0]        r_arr_a;
    logic [18:0]        r_arr_b;
    logic [18:0]        r_arr_c;
    logic               r_rsp_valid;
    logic               r_rsp_id;
    logic               r_rsp_x;
    logic [8:0]         r_rsp_f;
    logic [18:0]        r_rsp_s;

    logic               w_grant;
    logic               w_accept;
    logic               w_sel_x;
    logic [8:0]         w_sel_p;
    logic [17:0]        w_sel_a;
    logic [18:0]        w_sel_b;
    logic [18:0]        w_sel_c;

`ifdef GPCA_SCHED_RR_EN
    // Last granted requester; reset to 1 so requester 0 wins first contention
    logic r_ptr;

    // Round-robin grant: on contention the requester not granted last wins
    always_comb begin
        w_grant = ~req_valid[0];
        if (req_valid == 2'b11) begin
            w_grant = ~r_ptr;
        end
    end

    // Pointer moves only when a request is actually taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= 1'b1;
        end else if (w_accept) begin
            r_ptr <= w_grant;
        end
    end
`else
    // Fixed priority: requester 1 only wins when requester 0 is idle
    assign w_grant = ~req_valid[0];
`endif

    // Accept is possible only in IDLE; ready is forced low while in reset
    assign w_accept  = rst_n & (r_state == ST_IDLE) & (|req_valid);
    assign req_ready = w_accept ? (w_grant ? 2'b10 : 2'b01) : 2'b00;

    assign w_sel_x = w_grant ? req_x[1]      : req_x[0];
    assign w_sel_p = w_grant ? req_p[17:9]   : req_p[8:0];
    assign w_sel_a = w_grant ? req_a[35:18]  : req_a[17:0];
    assign w_sel_b = w_grant ? req_b[37:19]  : req_b[18:0];
    assign w_sel_c = w_grant ? req_c[37:19]  : req_c[18:0];

    // Sequencer: accept -> hold array inputs for the settle time -> respond
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_id        <= 1'b0;
            r_arr_x     <= 1'b0;
            r_arr_p     <= '0;
            r_arr_a     <= '0;
            r_arr_b     <= '0;
            r_arr_c     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_x     <= 1'b0;
            r_rsp_f     <= '0;
            r_rsp_s     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_arr_x <= w_sel_x;
                        r_arr_p <= w_sel_p;
                        r_arr_a <= w_sel_a;
                        r_arr_b <= w_sel_b;
                        r_arr_c <= w_sel_c;
                        r_id    <= w_grant;
                        r_cnt   <= c_CNT_LOAD;
                        r_state <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (r_cnt == '0) begin
                        r_rsp_f     <= arr_f;
                        r_rsp_s     <= arr_s;
                        r_rsp_x     <= r_arr_x;
                        r_rsp_id    <= r_id;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    // rsp_valid is known high here, so rsp_ready alone completes it
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign arr_x     = r_arr_x;
    assign arr_p     = r_arr_p;
    assign arr_a     = r_arr_a;
    assign arr_b     = r_arr_b;
    assign arr_c     = r_arr_c;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_x     = r_rsp_x;
    assign rsp_f     = r_rsp_f;
    assign rsp_s     = r_rsp_s;
    assign busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_gpca_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpca_sched
// Description : Self-checking bench for gpca_sched: directed scenarios plus a
//               randomized phase against a transaction-level reference model.
//               Honors GPCA_SCHED_RR_EN when defined at compile time.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpca_sched;

    localparam int S = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [1:0]  req_x = '0;
    logic [17:0] req_p = '0;
    logic [35:0] req_a = '0;
    logic [37:0] req_b = '0;
    logic [37:0] req_c = '0;
    logic        arr_x;
    logic [8:0]  arr_p;
    logic [17:0] arr_a;
    logic [18:0] arr_b;
    logic [18:0] arr_c;
    logic [8:0]  arr_f = '0;
    logic [18:0] arr_s = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic        rsp_id;
    logic        rsp_x;
    logic [8:0]  rsp_f;
    logic [18:0] rsp_s;
    logic        busy;

    // Second instance with the shortest settle time for the throughput test
    logic [1:0]  f_req_valid = '0;
    logic [1:0]  f_req_ready;
    logic        f_arr_x;
    logic [8:0]  f_arr_p;
    logic [17:0] f_arr_a;
    logic [18:0] f_arr_b;
    logic [18:0] f_arr_c;
    logic        f_rsp_valid;
    logic        f_rsp_ready = 1'b0;
    logic        f_rsp_id;
    logic        f_rsp_x;
    logic [8:0]  f_rsp_f;
    logic [18:0] f_rsp_s;
    logic        f_busy;

    gpca_sched #(.SETTLE_CYCLES(S)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x),
        .req_p(req_p), .req_a(req_a), .req_b(req_b), .req_c(req_c),
        .arr_x(arr_x), .arr_p(arr_p), .arr_a(arr_a), .arr_b(arr_b), .arr_c(arr_c),
        .arr_f(arr_f), .arr_s(arr_s),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_x(rsp_x), .rsp_f(rsp_f), .rsp_s(rsp_s), .busy(busy)
    );

    gpca_sched #(.SETTLE_CYCLES(1)) u_dut_fast (
        .clk(clk), .rst_n(rst_n),
        .req_valid(f_req_valid), .req_ready(f_req_ready), .req_x(2'b00),
        .req_p(18'h0), .req_a(36'h0), .req_b(38'h0), .req_c(38'h0),
        .arr_x(f_arr_x), .arr_p(f_arr_p), .arr_a(f_arr_a), .arr_b(f_arr_b), .arr_c(f_arr_c),
        .arr_f(9'h0), .arr_s(19'h0),
        .rsp_valid(f_rsp_valid), .rsp_ready(f_rsp_ready), .rsp_id(f_rsp_id),
        .rsp_x(f_rsp_x), .rsp_f(f_rsp_f), .rsp_s(f_rsp_s), .busy(f_busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    int          cyc = 0;
    int          m_due = 0;
    bit          m_inflight = 0;
    bit          m_rsp = 0;
    bit          m_prio = 0;
    bit          m_g;
    logic [1:0]  m_acc = '0;
    logic        m_id = 0, m_x = 0, m_rid = 0, m_rx = 0;
    logic [8:0]  m_p = '0, m_rf = '0;
    logic [17:0] m_a = '0;
    logic [18:0] m_b = '0, m_c = '0, m_rs = '0;

    function automatic bit pick();
        if (req_valid == 2'b11) begin
`ifdef GPCA_SCHED_RR_EN
            return m_prio;
`else
            return 1'b0;
`endif
        end
        return (req_valid == 2'b10);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_inflight = 0; m_rsp = 0; m_prio = 0; m_acc = '0;
            m_id = 0; m_x = 0; m_p = '0; m_a = '0; m_b = '0; m_c = '0;
            m_rid = 0; m_rx = 0; m_rf = '0; m_rs = '0;
        end else begin
            cyc++;
            m_acc = '0;
            if (m_rsp) begin
                if (rsp_ready) begin
                    m_rsp = 0;
                    m_inflight = 0;
                end
            end else if (m_inflight) begin
                if (cyc == m_due) begin
                    m_rf = arr_f; m_rs = arr_s; m_rx = m_x; m_rid = m_id;
                    m_rsp = 1;
                end
            end else if (req_valid != 2'b00) begin
                m_g = pick();
                m_acc[m_g] = 1'b1;
                m_x = req_x[m_g];
                m_p = req_p[9*m_g +: 9];
                m_a = req_a[18*m_g +: 18];
                m_b = req_b[19*m_g +: 19];
                m_c = req_c[19*m_g +: 19];
                m_id = m_g;
                m_due = cyc + S;
                m_prio = ~m_g;
                m_inflight = 1;
            end
        end
    end

    task automatic check_all(input string tag);
        logic [1:0] er;
        er = (rst_n && !m_inflight && req_valid != 2'b00) ? (2'b01 << pick()) : 2'b00;
        check({tag, ".req_ready"}, 64'(req_ready), 64'(er));
        check({tag, ".busy"}, 64'(busy), 64'(m_inflight));
        check({tag, ".arr_xpa"}, 64'({arr_x, arr_p, arr_a}), 64'({m_x, m_p, m_a}));
        check({tag, ".arr_bc"}, 64'({arr_b, arr_c}), 64'({m_b, m_c}));
        check({tag, ".rsp_valid"}, 64'(rsp_valid), 64'(m_rsp));
        check({tag, ".rsp_data"}, 64'({rsp_id, rsp_x, rsp_f, rsp_s}), 64'({m_rid, m_rx, m_rf, m_rs}));
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b0; f_req_valid = '0; f_rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drain(input string tag);
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 40 && m_inflight; k++) tick(tag);
        check({tag, ".drained_busy"}, 64'(busy), 64'(0));
        rsp_ready = 1'b0;
    endtask

    task automatic rand_payload(input int i);
        req_x[i]         = 1'($urandom);
        req_p[9*i +: 9]  = 9'($urandom);
        req_a[18*i +: 18] = 18'($urandom);
        req_b[19*i +: 19] = 19'($urandom);
        req_c[19*i +: 19] = 19'($urandom);
    endtask

    int          stamps[$];
    logic        ids[$];
    logic [63:0] snap_rsp, snap_arr1, snap_arr2;
    int          tcount;
    int          id1_seen;
    logic        exp_ids[4];

    initial begin
        // ---------------- reset ----------------
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        check("reset.busy", 64'(busy), 64'(0));
        check("reset.rsp_valid", 64'(rsp_valid), 64'(0));
        rst_n = 1'b1;

        // ---------------- throughput (SETTLE_CYCLES=1) ----------------
        f_req_valid = 2'b10;
        f_rsp_ready = 1'b1;
        tcount = 0;
        for (int k = 0; k < 60 && stamps.size() < 5; k++) begin
            @(posedge clk);
            #1;
            tcount++;
            if (f_req_valid[1] && f_req_ready[1]) stamps.push_back(tcount);
        end
        check("tput.count", 64'(stamps.size()), 64'(5));
        for (int i = 1; i < stamps.size(); i++)
            check("tput.gap", 64'(stamps[i] - stamps[i-1]), 64'(3));
        f_req_valid = '0;
        do_reset();

        // ---------------- single request ----------------
        req_x = 2'b01;
        req_p[8:0] = 9'h155; req_a[17:0] = 18'h2AAAA;
        req_b[18:0] = 19'h12345; req_c[18:0] = 19'h00F0F;
        arr_f = 9'h1A5; arr_s = 19'h54321;
        req_valid = 2'b01;
        tick("single");
        req_valid = 2'b00;
        check("single.arr_x", 64'(arr_x), 64'(1));
        check("single.arr_p", 64'(arr_p), 64'(9'h155));
        check("single.arr_a", 64'(arr_a), 64'(18'h2AAAA));
        check("single.arr_b", 64'(arr_b), 64'(19'h12345));
        check("single.arr_c", 64'(arr_c), 64'(19'h00F0F));
        for (int k = 1; k < S; k++) begin
            tick("single.wait");
            check("single.early_valid", 64'(rsp_valid), 64'(0));
        end
        tick("single.done");
        check("single.rsp_valid", 64'(rsp_valid), 64'(1));
        check("single.rsp_id", 64'(rsp_id), 64'(0));
        check("single.rsp_x", 64'(rsp_x), 64'(1));
        check("single.rsp_f", 64'(rsp_f), 64'(9'h1A5));
        check("single.rsp_s", 64'(rsp_s), 64'(19'h54321));
        drain("single");

        // ---------------- response backpressure ----------------
        rand_payload(1);
        req_valid = 2'b10;
        tick("bp");
        req_valid = 2'b00;
        for (int k = 0; k < 20 && !rsp_valid; k++) tick("bp.wait");
        check("bp.rsp_arrived", 64'(rsp_valid), 64'(1));
        snap_rsp  = 64'({rsp_id, rsp_x, rsp_f, rsp_s});
        snap_arr1 = 64'({arr_x, arr_p, arr_a});
        snap_arr2 = 64'({arr_b, arr_c});
        rand_payload(0);
        req_valid = 2'b11;
        for (int k = 0; k < 10; k++) begin
            arr_f = 9'($urandom); arr_s = 19'($urandom);
            tick("bp.hold");
            check("bp.rsp_stable", 64'({rsp_valid, rsp_id, rsp_x, rsp_f, rsp_s}), {33'h0, 1'b1, snap_rsp[29:0]});
            check("bp.arr_stable", 64'({arr_x, arr_p, arr_a}), snap_arr1);
            check("bp.arr_stable2", 64'({arr_b, arr_c}), snap_arr2);
            check("bp.ready_low", 64'(req_ready), 64'(0));
            check("bp.busy", 64'(busy), 64'(1));
        end
        rsp_ready = 1'b1;
        tick("bp.release");
        rsp_ready = 1'b0;
        check("bp.idle", 64'({rsp_valid, busy}), 64'(0));
        tick("bp.next_accept");
        check("bp.next_busy", 64'(busy), 64'(1));
        drain("bp");

        // ---------------- contention ----------------
        do_reset();
        rand_payload(0); rand_payload(1);
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        for (int k = 0; k < 80 && ids.size() < 4; k++) begin
            tick("cont");
            if (rsp_valid && rsp_ready) ids.push_back(rsp_id);
        end
        req_valid = 2'b00;
`ifdef GPCA_SCHED_RR_EN
        exp_ids = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_ids = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        check("cont.count", 64'(ids.size()), 64'(4));
        for (int i = 0; i < ids.size() && i < 4; i++)
            check("cont.id", 64'(ids[i]), 64'(exp_ids[i]));
        drain("cont");

        // ---------------- reset mid-op ----------------
        rand_payload(0);
        req_valid = 2'b01;
        tick("rstmid");
        req_valid = 2'b00;
        tick("rstmid.s1");
        tick("rstmid.s2");
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid.ready", 64'(req_ready), 64'(0));
        check("rstmid.busy", 64'(busy), 64'(0));
        check("rstmid.rsp", 64'({rsp_valid, rsp_id, rsp_x, rsp_f, rsp_s}), 64'(0));
        check("rstmid.arr", 64'({arr_x, arr_p, arr_a}), 64'(0));
        check("rstmid.arr2", 64'({arr_b, arr_c}), 64'(0));
        check_all("rstmid.all");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick("rstmid.quiet");
            check("rstmid.no_stale", 64'(rsp_valid), 64'(0));
        end
        rand_payload(0); rand_payload(1);
        req_valid = 2'b11;
        #1;
        check("rstmid.prio0", 64'(req_ready), 64'(2'b01));
        tick("rstmid.accept");
        req_valid = 2'b00;
        for (int k = 0; k < 20 && !rsp_valid; k++) tick("rstmid.wait");
        check("rstmid.rsp_valid", 64'(rsp_valid), 64'(1));
        check("rstmid.rsp_id", 64'(rsp_id), 64'(0));
        drain("rstmid");

        // ---------------- withdrawn request ----------------
        rand_payload(0);
        req_valid = 2'b01;
        tick("wd");
        req_valid = 2'b00;
        for (int k = 0; k < 20 && !rsp_valid; k++) tick("wd.wait");
        rand_payload(1);
        req_valid = 2'b10;
        tick("wd.pulse");
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        id1_seen = 0;
        for (int k = 0; k < 12; k++) begin
            tick("wd.after");
            if (rsp_valid && rsp_id) id1_seen++;
        end
        rsp_ready = 1'b0;
        check("wd.no_id1", 64'(id1_seen), 64'(0));
        check("wd.idle", 64'(busy), 64'(0));

        // ---------------- randomized ----------------
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (m_acc[i]) req_valid[i] = 1'b0;
                if (!req_valid[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        rand_payload(i);
                        req_valid[i] = 1'b1;
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            rsp_ready = 1'($urandom);
            arr_f = 9'($urandom);
            arr_s = 19'($urandom);
            tick("rand");
        end
        drain("rand");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gpca_sched.md
# gpca_sched

Two-port request scheduler and sequencer for the 9-row GPCA divide/square-root array. It accepts operation requests from two independent requesters over valid/ready handshakes and arbitrates between them. It registers the winning operand set onto the array inputs, waits a fixed number of settle cycles for the combinational array to resolve, captures the F/S results and returns them with the requester ID over a valid/ready response channel. The block sits between the datapath clients and the purely combinational `gpca` instance, and is the only driver of its inputs.

## Interface
- `SETTLE_CYCLES`, default 4: clock cycles the array inputs are held before results are sampled; legal range 1..15.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  2  per-requester request valid; bit i = requester i.
- `req_ready`  out  2  per-requester accept; at most one bit high.
- `req_x`  in  2  per-requester mode bit (GPCA X input).
- `req_p`  in  18  packed P operands; bits [9i+8:9i] = requester i.
- `req_a`  in  36  packed A operands; bits [18i+17:18i].
- `req_b`  in  38  packed B operands; bits [19i+18:19i].
- `req_c`  in  38  packed C operands; bits [19i+18:19i].
- `arr_x`, `arr_p`, `arr_a`, `arr_b`, `arr_c`  out  1/9/18/19/19  registered array inputs.
- `arr_f`  in  9  array F result.
- `arr_s`  in  19  array S result.
- `rsp_valid`  out  1  result valid.
- `rsp_ready`  in  1  consumer accepts the result.
- `rsp_id`  out  1  index of the requester that issued the result.
- `rsp_x`  out  1  mode bit of the completed operation.
- `rsp_f`  out  9  captured F.
- `rsp_s`  out  19  captured S.
- `busy`  out  1  high in SETTLE and RESP.

## Operation
- FSM states: IDLE, SETTLE, RESP. Reset state is IDLE.
- IDLE:
  - Arbiter selects a grant `g` among the asserted `req_valid` bits.
  - `req_ready[g]` is driven combinationally high in IDLE only. Outside IDLE, `req_ready` = 2'b00.
  - Accept occurs on an edge with `req_valid[g] & req_ready[g]`. At that edge:
    - load `arr_*` from requester g's fields;
    - latch `g` into the ID register;
    - load the settle counter with `SETTLE_CYCLES-1`;
    - move to SETTLE.
- SETTLE:
  - The counter decrements each cycle.
  - On the edge where the counter is 0, capture `arr_f`→`rsp_f`, `arr_s`→`rsp_s`, `arr_x`→`rsp_x` and ID→`rsp_id`. Set `rsp_valid`=1 and move to RESP.
- RESP:
  - Hold `rsp_*` stable until `rsp_valid & rsp_ready`.
  - On that edge, clear `rsp_valid` and return to IDLE.
- `arr_*` hold their value from accept until the next accept, and are never changed during SETTLE or RESP.
- Requesters hold valid and payload stable until accepted. Deasserting valid before accept is legal; the request is then simply not taken.
- Reset (asynchronous, any state, including mid-SETTLE or RESP):
  - FSM returns to IDLE and any in-flight operation is discarded.
  - `req_ready`=0, `rsp_valid`=0, `busy`=0.
  - `rsp_id`/`rsp_x`/`rsp_f`/`rsp_s`=0 and all `arr_*`=0.
  - Settle counter = 0 and the arbiter pointer is reset so requester 0 has priority.

## Timing
- Accept at edge T. Then:
  - `arr_*` are valid after T;
  - `rsp_valid` rises after edge T+SETTLE_CYCLES;
  - `busy` is high from T to the response handshake edge.
- If `rsp_ready` is already high when `rsp_valid` rises, the handshake completes at the next edge and the state is IDLE after it.
- The next accept is possible at the edge after that, giving minimum issue spacing of SETTLE_CYCLES+2 cycles.
- No combinational path from `arr_f`/`arr_s` or `rsp_ready` to any output. `req_ready` depends only on state and `req_valid`.

## Configuration
- `GPCA_SCHED_RR_EN` defined: round-robin arbitration.
  - A 1-bit pointer records the last granted requester; the other requester has priority on the next contention.
  - The pointer updates only on accept. After reset, requester 0 has priority.
- `GPCA_SCHED_RR_EN` undefined: fixed priority. Requester 0 always wins when both are valid, and there is no pointer register.

## Test plan
- **Single request:** reset, then requester 0 issues x=1, p=9'h155, a=18'h2AAAA, b=19'h12345, c=19'h00F0F. Bench stub drives arr_f=9'h1A5, arr_s=19'h54321.
  - `arr_*` equal the operands after the accept edge.
  - `rsp_valid` rises exactly 4 cycles later with rsp_id=0, rsp_x=1, rsp_f=9'h1A5, rsp_s=19'h54321.
- **Contention:** both requesters valid continuously for 4 ops.
  - With `GPCA_SCHED_RR_EN`: rsp_id sequence 0,1,0,1.
  - Without it: 0,0,0,0, and requester 1 is never accepted.
- **Response backpressure:** rsp_ready held low 10 cycles after rsp_valid.
  - `rsp_*` and `arr_*` stay constant, req_ready=0 and busy=1 throughout.
  - Raising rsp_ready completes the handshake in 1 cycle and the next accept follows one cycle later.
- **Back-to-back throughput:** rsp_ready tied high, requester 1 always valid, SETTLE_CYCLES=1 → one accept every 3 cycles.
- **Reset mid-op:** assert rst_n=0 two cycles into SETTLE.
  - All outputs read 0 immediately (asynchronous).
  - After release, no stale rsp_valid appears; a new request completes normally with requester 0 priority.
- **Withdrawn request:** requester 1 raises valid for one cycle while the block is in RESP, then drops it.
  - Never accepted; no rsp_id=1 response appears.
